uart_rx_arbiter_fifo: RTL and testbench
=======================================

UART_RX_ARBITER_FIFO -- requirements
Module: uart_rx_arbiter_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of received packet.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, programming address width.
REQ-003 SHALL have parameter DEPTH, default 8, receive FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have ports pkt_valid (input, 1) and pkt_data (input, DATA_WIDTH), one received UART byte per pulse.
REQ-007 SHALL have port programming, input, 1, which selects programming mode when high.
REQ-008 SHALL have ports cpu_req (input, 1), cpu_we (input, 1) and cpu_sel (input, 1), the CPU read request qualified by UART chip-select.
REQ-009 SHALL have ports rd_valid (output, 1) and rd_data (output, DATA_WIDTH), the CPU read response.
REQ-010 SHALL have ports prog_req, prog_we (output, 1), prog_addr (output, ADDR_WIDTH), prog_wdata (output, DATA_WIDTH) and prog_ack (input, 1), the memory write handshake.
REQ-011 SHALL have port fifo_count, output, clog2(DEPTH)+1, the current occupancy.
REQ-012 SHALL have ports overflow (output, 1) and ovf_clr (input, 1).

Function
REQ-013 SHALL push pkt_data into the FIFO on a pkt_valid cycle when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 SHALL drop pkt_data on pkt_valid when the FIFO is full and no pop occurs; stored contents SHALL stay unchanged.
REQ-015 SHALL, on a simultaneous push and pop, perform both operations and leave fifo_count unchanged.
REQ-016 SHALL implement FSM states IDLE, WRT_REQ and RD_DATA.
REQ-017 SHALL transition IDLE->WRT_REQ when programming=1 and the FIFO is not empty; this SHALL take priority.
REQ-018 SHALL transition IDLE->RD_DATA when programming=0, cpu_req=1, cpu_we=0 and cpu_sel=1.
REQ-019 SHALL, in WRT_REQ, drive prog_req=1, prog_we=1, prog_wdata=FIFO head and prog_addr=address counter; all four SHALL be 0 in other states.
REQ-020 SHALL, on prog_ack in WRT_REQ, pop the FIFO, increment the address counter modulo 2^ADDR_WIDTH and return to IDLE; without prog_ack it SHALL hold WRT_REQ.
REQ-021 SHALL, if programming falls while in WRT_REQ without prog_ack, return to IDLE with no pop.
REQ-022 SHALL clear the address counter to 0 on the cycle after the programming falling edge.
REQ-023 SHALL, in RD_DATA, drive rd_valid=1 for exactly one cycle (one cycle after the request is sampled), then return to IDLE.
REQ-024 SHALL, in RD_DATA with a non-empty FIFO, drive rd_data=head and pop.
REQ-025 SHALL, in RD_DATA with an empty FIFO, drive rd_data=0 and not pop.
REQ-026 SHALL drive rd_data=0 whenever rd_valid=0.
REQ-027 SHALL ignore cpu_req while not in IDLE.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, the FIFO empty (fifo_count=0), the address counter 0 and overflow 0; all outputs SHALL be 0.
REQ-029 SHALL, on rst asserted mid-handshake, abandon the transfer immediately, with no pop and no further prog_req.

Configuration
REQ-030 SHALL, with macro UART_RX_ARB_OVF_EN defined, set overflow sticky to 1 on any drop (REQ-014); ovf_clr=1 SHALL clear it next cycle, and a drop on the same cycle as ovf_clr SHALL win.
REQ-031 SHALL, without UART_RX_ARB_OVF_EN, tie overflow to 0 and ignore ovf_clr; FIFO behaviour SHALL be unchanged.

Verification
REQ-032 Bench SHALL cover: programming=1, push 0x11,0x22,0x33, prog_ack one cycle after each prog_req -> writes to addr 0,1,2 with data 0x11,0x22,0x33, fifo_count ends 0.
REQ-033 Bench SHALL cover: programming=0, push 0xA5, cpu_req/cpu_sel=1, cpu_we=0 -> rd_valid=1 one cycle later with rd_data=0xA5; a second read gives rd_valid=1 with rd_data=0x00.
REQ-034 Bench SHALL cover: DEPTH=8, push 9 bytes with no pop -> fifo_count=8, 9th byte lost, overflow=1 (macro on) or 0 (macro off); ovf_clr -> overflow=0.
REQ-035 Bench SHALL cover: FIFO full, pkt_valid coincident with prog_ack -> fifo_count stays 8 and the new byte is stored at the tail.
REQ-036 Bench SHALL cover: programming drops while in WRT_REQ with no ack -> IDLE, fifo_count unchanged, next programming session starts at addr 0.
REQ-037 Bench SHALL cover: rst pulse mid WRT_REQ -> prog_req=0 immediately, fifo_count=0, prog_addr=0.

Source files
------------

// File: rtl/uart_rx_arbiter_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_arbiter_fifo_if
// Brief  : Byte input, CPU read, memory-programming and status signals.
// Rev    : 1.0
// ============================================================================
interface uart_rx_arbiter_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] pkt_data;
  logic                  programming;
  logic                  cpu_req;
  logic                  cpu_we;
  logic                  cpu_sel;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  prog_req;
  logic                  prog_we;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [DATA_WIDTH-1:0] prog_wdata;
  logic                  prog_ack;
  logic [CW-1:0]         fifo_count;
  logic                  overflow;
  logic                  ovf_clr;

  modport slave (
    input  pkt_valid, pkt_data, programming, cpu_req, cpu_we, cpu_sel,
           prog_ack, ovf_clr,
    output rd_valid, rd_data, prog_req, prog_we, prog_addr, prog_wdata,
           fifo_count, overflow
  );

  modport master (
    output pkt_valid, pkt_data, programming, cpu_req, cpu_we, cpu_sel,
           prog_ack, ovf_clr,
    input  rd_valid, rd_data, prog_req, prog_we, prog_addr, prog_wdata,
           fifo_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_arbiter_fifo
// Brief  : UART byte FIFO shared between a memory programmer and CPU reads.
//          Define UART_RX_ARB_OVF_EN to enable the sticky overflow flag.
// Rev    : 1.0
// ============================================================================
module uart_rx_arbiter_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_rx_arbiter_fifo_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRT_REQ = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  prog_d;
  logic                  full, empty, push, pop, drop;
  logic [DATA_WIDTH-1:0] head;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push  = bus.pkt_valid && (!full || pop);
  assign drop  = bus.pkt_valid && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    bus.rd_valid   = 1'b0;
    bus.rd_data    = '0;
    bus.prog_req   = 1'b0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;
    case (state)
      IDLE: begin
        if (bus.programming && !empty)
          state_nxt = WRT_REQ;
        else if (!bus.programming && bus.cpu_req && !bus.cpu_we && bus.cpu_sel)
          state_nxt = RD_DATA;
      end
      WRT_REQ: begin
        bus.prog_req   = 1'b1;
        bus.prog_we    = 1'b1;
        bus.prog_addr  = addr;
        bus.prog_wdata = head;
        if (bus.prog_ack) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end else if (!bus.programming) begin
          state_nxt = IDLE;
        end
      end
      RD_DATA: begin
        bus.rd_valid = 1'b1;
        if (!empty) begin
          bus.rd_data = head;
          pop         = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.pkt_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Address restarts at 0 once programming has been seen to drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      prog_d <= 1'b0;
    end else begin
      prog_d <= bus.programming;
      if (prog_d && !bus.programming)
        addr <= '0;
      else if (state == WRT_REQ && bus.prog_ack)
        addr <= addr + ADDR_WIDTH'(1);
    end
  end

  assign bus.fifo_count = count;

`ifdef UART_RX_ARB_OVF_EN
  logic ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovf <= 1'b0;
    else if (drop)        ovf <= 1'b1;
    else if (bus.ovf_clr) ovf <= 1'b0;
  end
  assign bus.overflow = ovf;
`else
  logic unused_ovf;
  assign unused_ovf   = bus.ovf_clr | drop;
  assign bus.overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_arbiter_fifo
// Brief  : Directed self-checking bench for uart_rx_arbiter_fifo.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_arbiter_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

`ifdef UART_RX_ARB_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  uart_rx_arbiter_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(8)) bus ();

  uart_rx_arbiter_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = d;
    tick();
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = 8'h00;
  endtask

  task automatic wait_prog_req();
    int n = 0;
    while (bus.prog_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("prog_req_wait", {31'd0, bus.prog_req}, 32'd1);
  endtask

  task automatic ack_write(input logic [15:0] a, input logic [7:0] d, input string tag);
    wait_prog_req();
    check({tag, "_addr"},  {16'd0, bus.prog_addr}, {16'd0, a});
    check({tag, "_wdata"}, {24'd0, bus.prog_wdata}, {24'd0, d});
    check({tag, "_we"},    {31'd0, bus.prog_we}, 32'd1);
    bus.prog_ack = 1'b1;
    tick();
    bus.prog_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_d [8];
    bus.pkt_valid = 0; bus.pkt_data = 0; bus.programming = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_sel = 0;
    bus.prog_ack = 0; bus.ovf_clr = 0;
    rst = 1'b1;
    tick(); tick();
    check("rst_count",    {28'd0, bus.fifo_count}, 32'd0);
    check("rst_prog_req", {31'd0, bus.prog_req}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // CPU read of one byte, then a read of an empty FIFO
    push_byte(8'hA5);
    check("rd_count1", {28'd0, bus.fifo_count}, 32'd1);
    bus.cpu_req = 1; bus.cpu_sel = 1; bus.cpu_we = 0;
    tick();
    bus.cpu_req = 0;
    check("rd1_valid", {31'd0, bus.rd_valid}, 32'd1);
    check("rd1_data",  {24'd0, bus.rd_data}, 32'hA5);
    tick();
    check("rd1_valid_low", {31'd0, bus.rd_valid}, 32'd0);
    check("rd1_data_low",  {24'd0, bus.rd_data}, 32'd0);
    check("rd1_count0",    {28'd0, bus.fifo_count}, 32'd0);
    bus.cpu_req = 1;
    tick();
    bus.cpu_req = 0; bus.cpu_sel = 0;
    check("rd2_valid", {31'd0, bus.rd_valid}, 32'd1);
    check("rd2_data",  {24'd0, bus.rd_data}, 32'h00);
    tick();
    check("rd2_count", {28'd0, bus.fifo_count}, 32'd0);

    // Programming session: three bytes to addresses 0..2
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    check("prog_count3", {28'd0, bus.fifo_count}, 32'd3);
    bus.programming = 1;
    ack_write(16'd0, 8'h11, "p0");
    ack_write(16'd1, 8'h22, "p1");
    ack_write(16'd2, 8'h33, "p2");
    tick();
    check("prog_count_end", {28'd0, bus.fifo_count}, 32'd0);
    check("prog_req_idle",  {31'd0, bus.prog_req}, 32'd0);
    bus.programming = 0;
    tick();

    // Fill past capacity; the ninth byte is dropped
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    check("ovf_count8", {28'd0, bus.fifo_count}, 32'd8);
    check("ovf_flag",   {31'd0, bus.overflow}, {31'd0, OVF_EXP});
    bus.ovf_clr = 1;
    tick();
    bus.ovf_clr = 0;
    check("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

    // Full FIFO: a push coincident with the programming pop is kept
    bus.programming = 1;
    wait_prog_req();
    check("full_addr0", {16'd0, bus.prog_addr}, 32'd0);
    check("full_head",  {24'd0, bus.prog_wdata}, 32'h01);
    bus.prog_ack = 1; bus.pkt_valid = 1; bus.pkt_data = 8'hAA;
    tick();
    bus.prog_ack = 0; bus.pkt_valid = 0;
    check("full_count_kept", {28'd0, bus.fifo_count}, 32'd8);
    check("full_no_ovf",     {31'd0, bus.overflow}, 32'd0);
    exp_d = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
    for (int i = 0; i < 8; i++) ack_write(16'(i + 1), exp_d[i], "drain");
    tick();
    check("drain_count0", {28'd0, bus.fifo_count}, 32'd0);
    bus.programming = 0;
    tick();

    // Programming falls during WRT_REQ with no ack
    push_byte(8'h5C); push_byte(8'h6D);
    bus.programming = 1;
    wait_prog_req();
    check("abort_addr0", {16'd0, bus.prog_addr}, 32'd0);
    tick();
    check("abort_hold", {31'd0, bus.prog_req}, 32'd1);
    bus.programming = 0;
    tick();
    check("abort_idle",  {31'd0, bus.prog_req}, 32'd0);
    check("abort_count", {28'd0, bus.fifo_count}, 32'd2);
    tick();
    bus.programming = 1;
    ack_write(16'd0, 8'h5C, "resume");
    wait_prog_req();
    check("resume_addr1", {16'd0, bus.prog_addr}, 32'd1);

    // Asynchronous reset in the middle of a handshake
    rst = 1'b1;
    #1;
    check("rst_mid_req",   {31'd0, bus.prog_req}, 32'd0);
    check("rst_mid_count", {28'd0, bus.fifo_count}, 32'd0);
    check("rst_mid_addr",  {16'd0, bus.prog_addr}, 32'd0);
    bus.programming = 0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_req", {31'd0, bus.prog_req}, 32'd0);

    // Drop coincident with ovf_clr: the drop wins
    for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i));
    bus.ovf_clr = 1;
    push_byte(8'hFF);
    bus.ovf_clr = 0;
    check("ovf_clr_race", {31'd0, bus.overflow}, {31'd0, OVF_EXP});
    check("ovf_race_count", {28'd0, bus.fifo_count}, 32'd8);
    bus.ovf_clr = 1;
    tick();
    bus.ovf_clr = 0;
    check("ovf_race_clear", {31'd0, bus.overflow}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
